// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//   Back end of the FP adder: takes the aligned add/subtract result, normalizes
//   it with one left shift per cycle, rounds to nearest-even and packs an
//   IEEE-754 word.
//
//   Ports
//     clk, reset                  clock (rising edge), async active-high reset
//     in_valid / in_ready         upstream handshake (ready only in IDLE)
//     in_sign, in_exponent        sign, larger biased exponent
//     in_carry                    carry-out of the mantissa add
//     in_mantissa                 [FRAC_W+1] hidden, [FRAC_W:1] fraction, [0] guard
//     in_sticky                   OR of bits shifted out below guard
//     out_valid / out_ready       downstream handshake
//     out_result                  packed {sign, exponent, fraction}
//     out_overflow                result is infinity due to overflow
//     out_zero                    encoded magnitude is zero
//
//   Build option
//     FPNORM_FTZ_EN               flush would-be subnormal results to signed zero

module fp_normalize_round #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exponent,
    input  logic                      in_carry,
    input  logic [FRAC_W+1:0]         in_mantissa,
    input  logic                      in_sticky,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_overflow,
    output logic                      out_zero
);

    localparam int unsigned MW = FRAC_W + 2;
    localparam int unsigned RW = EXP_W + FRAC_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        NORM,
        ROUND,
        DONE
    } stateT;

    stateT state, stateNext;

    logic              sgnQ;
    logic [EXP_W-1:0]  expQ;
    logic              carryQ;
    logic [MW-1:0]     mantQ;
    logic              stickyQ;
    logic              specialQ;
    logic [RW-1:0]     resultQ;
    logic              overflowQ;
    logic              zeroQ;

    logic              accept;

    // PREP datapath
    logic [MW-1:0]     prepMant;
    logic [EXP_W-1:0]  prepExp;
    logic              prepSticky;
    logic              prepSpecial;
    logic [RW-1:0]     prepResult;
    logic              prepOvf;
    logic              prepZero;
    logic              prepToNorm;

    // NORM datapath
    logic [MW-1:0]     normMant;
    logic [EXP_W-1:0]  normExp;
    logic              normDone;

    // ROUND datapath
    logic              roundUp;
    logic [FRAC_W:0]   fracSum;
    logic              fracCarry;
    logic              hiddenFinal;
    logic [EXP_W-1:0]  roundExp;
    logic [FRAC_W-1:0] roundFrac;
    logic [RW-1:0]     roundResult;
    logic              roundOvf;
    logic              roundZero;

    assign in_ready     = (state == IDLE) && !reset;
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state == DONE);
    assign out_result   = resultQ;
    assign out_overflow = overflowQ;
    assign out_zero     = zeroQ;

    // ------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------
    always_comb begin
        prepMant    = mantQ;
        prepExp     = expQ;
        prepSticky  = stickyQ;
        prepSpecial = 1'b0;
        prepResult  = '0;
        prepOvf     = 1'b0;
        prepZero    = 1'b0;

        if (carryQ) begin
            prepMant   = {1'b1, mantQ[MW-1:1]};
            prepSticky = stickyQ | mantQ[0];
            prepExp    = expQ + EXP_ONE;
        end

        if (expQ == EXP_MAX) begin
            prepSpecial = 1'b1;
            prepResult  = {sgnQ, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (carryQ && (prepExp == EXP_MAX)) begin
            prepSpecial = 1'b1;
            prepResult  = {sgnQ, EXP_MAX, {FRAC_W{1'b0}}};
            prepOvf     = 1'b1;
        end else if (!carryQ && (mantQ == '0)) begin
            prepSpecial = 1'b1;
            prepResult  = '0;
            prepZero    = 1'b1;
        end

        prepToNorm = !prepSpecial && !prepMant[MW-1] && (prepExp > EXP_ONE);

        normMant = {mantQ[MW-2:0], 1'b0};
        normExp  = expQ - EXP_ONE;
        normDone = normMant[MW-1] || (normExp == EXP_ONE);

        // A result reaching ROUND with hidden bit clear always has expQ==1,
        // so a carry into the hidden bit yields the smallest normal exponent.
        roundUp     = mantQ[0] & (stickyQ | mantQ[1]);
        fracSum     = {1'b0, mantQ[FRAC_W:1]} + (FRAC_W + 1)'(roundUp);
        fracCarry   = fracSum[FRAC_W];
        hiddenFinal = mantQ[MW-1] | fracCarry;
        roundFrac   = fracCarry ? '0 : fracSum[FRAC_W-1:0];
        if (!hiddenFinal) begin
            roundExp = '0;
        end else if (mantQ[MW-1]) begin
            roundExp = fracCarry ? (expQ + EXP_ONE) : expQ;
        end else begin
            roundExp = EXP_ONE;
        end

        roundOvf    = 1'b0;
        roundResult = {sgnQ, roundExp, roundFrac};
        if (hiddenFinal && (roundExp == EXP_MAX)) begin
            roundOvf    = 1'b1;
            roundResult = {sgnQ, EXP_MAX, {FRAC_W{1'b0}}};
        end
`ifdef FPNORM_FTZ_EN
        if (!mantQ[MW-1]) begin
            roundOvf    = 1'b0;
            roundResult = {sgnQ, {(RW - 1){1'b0}}};
        end
`endif
        roundZero = (roundResult[RW-2:0] == '0);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Special cases detected in PREP still pass through ROUND so that every
    // result has the same minimum latency; ROUND leaves them untouched.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = PREP;
            PREP:    stateNext = prepToNorm ? NORM : ROUND;
            NORM:    if (normDone) stateNext = ROUND;
            ROUND:   stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sgnQ      <= 1'b0;
            expQ      <= '0;
            carryQ    <= 1'b0;
            mantQ     <= '0;
            stickyQ   <= 1'b0;
            specialQ  <= 1'b0;
            resultQ   <= '0;
            overflowQ <= 1'b0;
            zeroQ     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sgnQ     <= in_sign;
                        expQ     <= (in_exponent == '0) ? EXP_ONE : in_exponent;
                        carryQ   <= in_carry;
                        mantQ    <= in_mantissa;
                        stickyQ  <= in_sticky;
                        specialQ <= 1'b0;
                    end
                end
                PREP: begin
                    mantQ    <= prepMant;
                    expQ     <= prepExp;
                    stickyQ  <= prepSticky;
                    specialQ <= prepSpecial;
                    if (prepSpecial) begin
                        resultQ   <= prepResult;
                        overflowQ <= prepOvf;
                        zeroQ     <= prepZero;
                    end
                end
                NORM: begin
                    mantQ <= normMant;
                    expQ  <= normExp;
                end
                ROUND: begin
                    if (!specialQ) begin
                        resultQ   <= roundResult;
                        overflowQ <= roundOvf;
                        zeroQ     <= roundZero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round (default build, gradual underflow).
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic        in_carry;
    logic [24:0] in_mantissa;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_normalize_round #(
        .EXP_W (8),
        .FRAC_W(23)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exponent (in_exponent),
        .in_carry    (in_carry),
        .in_mantissa (in_mantissa),
        .in_sticky   (in_sticky),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_overflow(out_overflow),
        .out_zero    (out_zero)
    );

    typedef struct {
        string       name;
        logic        sign;
        logic [7:0]  exp;
        logic        carry;
        logic [24:0] mant;
        logic        sticky;
        logic [31:0] result;
        logic        ovf;
        logic        zero;
        int          lat;
    } vecT;

    localparam int NV = 18;
    vecT vecs [NV];

    function automatic vecT mk(input string n, input logic s, input logic [7:0] e,
                               input logic c, input logic [24:0] m, input logic st,
                               input logic [31:0] r, input logic o, input logic z,
                               input int l);
        vecT v;
        v.name = n; v.sign = s; v.exp = e; v.carry = c; v.mant = m; v.sticky = st;
        v.result = r; v.ovf = o; v.zero = z; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents one operand set and returns just after the accept edge.
    task automatic sendVec(input vecT v);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        in_sign     = v.sign;
        in_exponent = v.exp;
        in_carry    = v.carry;
        in_mantissa = v.mant;
        in_sticky   = v.sticky;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic waitValid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic runVec(input vecT v);
        int cyc;
        sendVec(v);
        waitValid(cyc);
        check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        check({v.name, " latency"}, 32'(cyc), 32'(v.lat));
        check({v.name, " result"}, out_result, v.result);
        check({v.name, " overflow"}, 32'(out_overflow), 32'(v.ovf));
        check({v.name, " zero"}, 32'(out_zero), 32'(v.zero));
        check({v.name, " in_ready busy"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({v.name, " valid drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vecs[0]  = mk("one_plus_one",    0, 8'h7F, 1, 25'h0000000, 0, 32'h40000000, 0, 0, 3);
        vecs[1]  = mk("cancel",          0, 8'h7F, 0, 25'h0800000, 0, 32'h3F000000, 0, 0, 4);
        vecs[2]  = mk("exact_zero",      1, 8'h7F, 0, 25'h0000000, 0, 32'h00000000, 0, 1, 3);
        vecs[3]  = mk("rne_tie_up",      0, 8'h7F, 0, 25'h1000003, 0, 32'h3F800002, 0, 0, 3);
        vecs[4]  = mk("rne_tie_even",    0, 8'h7F, 0, 25'h1000001, 0, 32'h3F800000, 0, 0, 3);
        vecs[5]  = mk("rne_sticky",      0, 8'h7F, 0, 25'h1000001, 1, 32'h3F800001, 0, 0, 3);
        vecs[6]  = mk("carry_overflow",  0, 8'hFE, 1, 25'h0000000, 0, 32'h7F800000, 1, 0, 3);
        vecs[7]  = mk("round_exp_carry", 0, 8'h7F, 0, 25'h1FFFFFF, 0, 32'h40000000, 0, 0, 3);
        vecs[8]  = mk("round_overflow",  1, 8'hFE, 0, 25'h1FFFFFF, 0, 32'hFF800000, 1, 0, 3);
        vecs[9]  = mk("inf_nan_in",      1, 8'hFF, 0, 25'h1234567, 1, 32'hFF800000, 0, 0, 3);
        vecs[10] = mk("subnormal",       0, 8'h00, 0, 25'h0800000, 0, 32'h00400000, 0, 0, 3);
        vecs[11] = mk("subn_round_norm", 0, 8'h00, 0, 25'h0FFFFFF, 0, 32'h00800000, 0, 0, 3);
        vecs[12] = mk("norm_to_min_exp", 0, 8'h03, 0, 25'h0000002, 0, 32'h00000004, 0, 0, 5);
        vecs[13] = mk("norm_max_24",     0, 8'h7F, 0, 25'h0000001, 0, 32'h33800000, 0, 0, 27);
        vecs[14] = mk("carry_sticky",    0, 8'h7F, 1, 25'h0000003, 0, 32'h40000001, 0, 0, 3);
        vecs[15] = mk("carry_no_sticky", 0, 8'h7F, 1, 25'h0000002, 0, 32'h40000000, 0, 0, 3);
        vecs[16] = mk("neg_one",         1, 8'h7F, 0, 25'h1000000, 0, 32'hBF800000, 0, 0, 3);
        vecs[17] = mk("round_to_zero",   0, 8'h00, 0, 25'h0000001, 0, 32'h00000000, 0, 1, 3);

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = '0;
        in_carry    = 1'b0;
        in_mantissa = '0;
        in_sticky   = 1'b0;
        out_ready   = 1'b1;

        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", out_result, 32'h0);
        check("reset flags", {30'd0, out_overflow, out_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            runVec(vecs[i]);
        end

        // Backpressure: result held for 5 cycles, then handshake and in_ready returns.
        out_ready = 1'b0;
        runVec(vecs[3]);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_result", out_result, 32'h3F800002);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

        // Reset while in DONE aborts immediately.
        out_ready = 1'b0;
        sendVec(vecs[0]);
        waitValid(cyc);
        check("rst_done reached", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_done out_valid", 32'(out_valid), 32'd0);
        check("rst_done out_result", out_result, 32'h0);
        check("rst_done in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_done in_ready after", 32'(in_ready), 32'd1);

        // Reset during NORM discards the captured operand; next op is clean.
        sendVec(vecs[13]);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_norm out_valid", 32'(out_valid), 32'd0);
        check("rst_norm in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_norm in_ready after", 32'(in_ready), 32'd1);
        runVec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
